// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: derives a pixel-enable from the system clock, runs the
// horizontal/vertical counters, and registers sync/blank/RGB one pixel after the address.
module vga_timing_gen #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        frame_start,
    output logic        pclk,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);

    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    logic        pix_en_q, pix_en_d;
    logic        tick;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        h_wrap, v_wrap;
    logic        h_act, v_act, disp_act;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        valid_q, valid_d;
    logic        frame_start_q, frame_start_d;
    logic [23:0] rgb_q, rgb_d;

    // Every other clk edge is a pixel tick; pix_en doubles as the 25 MHz pixel clock.
    assign tick     = pix_en_q;
    assign pix_en_d = ~pix_en_q;

    assign h_wrap   = (h_cnt_q == H_LAST);
    assign v_wrap   = (v_cnt_q == V_LAST);
    assign h_act    = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    assign v_act    = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign disp_act = h_act && v_act;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        h_addr = '0;
        v_addr = '0;
        if (disp_act) begin
            h_addr = h_cnt_q - H_ACT_BEG;
            v_addr = v_cnt_q - V_ACT_BEG;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            end
        end
    end

    // Output stage samples the pre-tick counters, so it lags the address by one pixel
    // and lines up with the colour the source returned for that address.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        valid_d       = valid_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        if (tick) begin
            hsync_d       = !(h_cnt_q < H_SYNC_END);
            vsync_d       = !(v_cnt_q < V_SYNC_END);
            valid_d       = disp_act;
            rgb_d         = disp_act ? vga_data : 24'h000000;
            frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            valid_q       <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge state.
            pix_en_q      <= pix_en_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            valid_q       <= valid_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pclk                  = pix_en_q;
    assign hsync                 = hsync_q;
    assign vsync                 = vsync_q;
    assign valid                 = valid_q;
    assign frame_start           = frame_start_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken
// instance for whole frames, both compared every cycle against a raster-position model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        int hs; int hb; int ha; int hf;
        int vs; int vb; int va; int vf;
    } timing_t;

    typedef struct packed {
        logic [9:0]  ha;
        logic [9:0]  va;
        logic        fs;
        logic        pc;
        logic        hs;
        logic        vs;
        logic        vl;
        logic [23:0] rgb;
    } vga_out_t;

    localparam timing_t CFG_D = '{hs:96, hb:48, ha:640, hf:16, vs:2, vb:33, va:480, vf:10};
    localparam timing_t CFG_S = '{hs:8,  hb:4,  ha:16,  hf:4,  vs:2, vb:3,  va:6,   vf:2};
    localparam int S_FRAME = (8 + 4 + 16 + 4) * (2 + 3 + 6 + 2);
    localparam vga_out_t RESET_OUT = '{ha:10'd0, va:10'd0, fs:1'b0, pc:1'b0, hs:1'b1,
                                       vs:1'b1, vl:1'b0, rgb:24'h000000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;          // 0: colour encodes address, 1: all-ones colour

    logic [23:0] d_data, s_data;
    logic [9:0]  d_h_addr, d_v_addr, s_h_addr, s_v_addr;
    logic        d_fs, d_pclk, d_hsync, d_vsync, d_valid;
    logic        s_fs, s_pclk, s_hsync, s_vsync, s_valid;
    logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;

    int checks = 0;
    int errors = 0;
    int edges = 0;              // clk edges since reset release
    logic tick_mode = 1'b0;     // data mode seen at the most recent pixel tick

    assign d_data = mode ? 24'hFFFFFF : {d_h_addr[7:0], d_v_addr[7:0], 8'hA5};
    assign s_data = mode ? 24'hFFFFFF : {s_h_addr[7:0], s_v_addr[7:0], 8'hA5};

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .vga_data(d_data),
        .h_addr(d_h_addr), .v_addr(d_v_addr), .frame_start(d_fs), .pclk(d_pclk),
        .hsync(d_hsync), .vsync(d_vsync), .valid(d_valid),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    vga_timing_gen #(
        .H_SYNC(8), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6),  .V_FRONT(2)
    ) dut_s (
        .clk(clk), .rst(rst), .vga_data(s_data),
        .h_addr(s_h_addr), .v_addr(s_v_addr), .frame_start(s_fs), .pclk(s_pclk),
        .hsync(s_hsync), .vsync(s_vsync), .valid(s_valid),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edges, $time);
        end
    endtask

    function automatic bit visible(input timing_t t, input int h, input int v);
        return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.ha) &&
               (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.va);
    endfunction

    // After e edges, e/2 pixel ticks have happened: the address shows raster position
    // e/2, the registered outputs describe position e/2-1.
    function automatic vga_out_t expect_out(input timing_t t, input int e, input logic md);
        int htot, ftot, pos, h, v;
        vga_out_t r;
        htot = t.hs + t.hb + t.ha + t.hf;
        ftot = htot * (t.vs + t.vb + t.va + t.vf);
        r = RESET_OUT;
        r.pc = (e % 2 == 1);
        pos = (e / 2) % ftot;
        h = pos % htot;
        v = pos / htot;
        if (visible(t, h, v)) begin
            r.ha = 10'(h - t.hs - t.hb);
            r.va = 10'(v - t.vs - t.vb);
        end
        if (e >= 2) begin
            pos = (e / 2 - 1) % ftot;
            h = pos % htot;
            v = pos / htot;
            r.hs = (h >= t.hs);
            r.vs = (v >= t.vs);
            r.vl = visible(t, h, v);
            if (r.vl)
                r.rgb = md ? 24'hFFFFFF : {8'(h - t.hs - t.hb), 8'(v - t.vs - t.vb), 8'hA5};
            r.fs = (e % 2 == 0) && (pos == 0);
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                edges = 0;
            end else begin
                edges = edges + 1;
                if (edges % 2 == 0) tick_mode = mode;
            end
        end
    end

    // Per-cycle comparison plus pulse-width/period measurements and pinned literals.
    initial begin
        vga_out_t act_d, act_s;
        int d_hs_fall, d_vs_fall, d_vl_rise, s_vs_fall, s_fs_last, s_vl_rise, s_runs;
        logic d_hs_p, d_vs_p, d_vl_p, s_vs_p, s_fs_p, s_vl_p;
        d_hs_fall = -1; d_vs_fall = -1; d_vl_rise = -1;
        s_vs_fall = -1; s_fs_last = -1; s_vl_rise = -1; s_runs = 0;
        d_hs_p = 1'b1; d_vs_p = 1'b1; d_vl_p = 1'b0;
        s_vs_p = 1'b1; s_fs_p = 1'b0; s_vl_p = 1'b0;
        forever begin
            @(negedge clk);
            act_d = {d_h_addr, d_v_addr, d_fs, d_pclk, d_hsync, d_vsync, d_valid, d_r, d_g, d_b};
            act_s = {s_h_addr, s_v_addr, s_fs, s_pclk, s_hsync, s_vsync, s_valid, s_r, s_g, s_b};
            check("dflt_out", 64'(act_d), 64'(expect_out(CFG_D, edges, tick_mode)));
            check("small_out", 64'(act_s), 64'(expect_out(CFG_S, edges, tick_mode)));
            if (rst) begin
                d_hs_fall = -1; d_vs_fall = -1; d_vl_rise = -1;
                s_vs_fall = -1; s_fs_last = -1; s_vl_rise = -1; s_runs = 0;
            end else begin
                case (edges)
                    1: begin
                        check("pclk_first_edge", 64'(d_pclk), 64'(1));
                        check("hsync_before_first_tick", 64'(d_hsync), 64'(1));
                    end
                    2: begin
                        check("hsync_low_second_edge", 64'(d_hsync), 64'(0));
                        check("frame_start_second_edge", 64'(d_fs), 64'(1));
                        check("small_frame_start_second_edge", 64'(s_fs), 64'(1));
                    end
                    3: check("frame_start_one_clk", 64'(d_fs), 64'(0));
                    694: begin
                        check("small_last_visible_h", 64'(s_h_addr), 64'(15));
                        check("small_last_visible_v", 64'(s_v_addr), 64'(5));
                    end
                    696: begin
                        check("small_after_last_h", 64'(s_h_addr), 64'(0));
                        check("small_last_valid", 64'(s_valid), 64'(1));
                        check("small_last_rgb", 64'({s_r, s_g, s_b}), 64'(24'h0F05A5));
                    end
                    698: check("small_valid_falls", 64'(s_valid), 64'(0));
                    832: check("small_no_fs_at_wrap_tick", 64'(s_fs), 64'(0));
                    834: begin
                        check("small_fs_after_wrap", 64'(s_fs), 64'(1));
                        check("small_hsync_after_wrap", 64'(s_hsync), 64'(0));
                        check("small_vsync_after_wrap", 64'(s_vsync), 64'(0));
                    end
                    835: check("small_fs_one_clk", 64'(s_fs), 64'(0));
                    56286: check("dflt_addr_h143", 64'(d_h_addr), 64'(0));
                    56288: begin
                        check("dflt_first_visible_h", 64'(d_h_addr), 64'(0));
                        check("dflt_first_visible_v", 64'(d_v_addr), 64'(0));
                        check("dflt_valid_lags_addr", 64'(d_valid), 64'(0));
                    end
                    56290: begin
                        check("dflt_first_valid", 64'(d_valid), 64'(1));
                        check("dflt_first_rgb", 64'({d_r, d_g, d_b}), 64'(24'h0000A5));
                        check("dflt_second_h", 64'(d_h_addr), 64'(1));
                    end
                    default: ;
                endcase

                if (d_hs_p && !d_hsync) begin
                    if (d_hs_fall >= 0) check("dflt_hsync_period", 64'(edges - d_hs_fall), 64'(1600));
                    d_hs_fall = edges;
                end
                if (!d_hs_p && d_hsync && d_hs_fall >= 0)
                    check("dflt_hsync_low", 64'(edges - d_hs_fall), 64'(192));
                if (d_vs_p && !d_vsync) d_vs_fall = edges;
                if (!d_vs_p && d_vsync && d_vs_fall >= 0)
                    check("dflt_vsync_low", 64'(edges - d_vs_fall), 64'(3200));
                if (!d_vl_p && d_valid) d_vl_rise = edges;
                if (d_vl_p && !d_valid && d_vl_rise >= 0)
                    check("dflt_valid_run", 64'(edges - d_vl_rise), 64'(1280));

                if (s_vs_p && !s_vsync) begin
                    if (s_vs_fall >= 0) check("small_vsync_period", 64'(edges - s_vs_fall), 64'(832));
                    s_vs_fall = edges;
                end
                if (!s_vs_p && s_vsync && s_vs_fall >= 0)
                    check("small_vsync_low", 64'(edges - s_vs_fall), 64'(128));
                if (!s_fs_p && s_fs) begin
                    if (s_fs_last >= 0) begin
                        check("small_fs_period", 64'(edges - s_fs_last), 64'(832));
                        check("small_valid_lines", 64'(s_runs), 64'(6));
                    end
                    s_fs_last = edges;
                    s_runs = 0;
                end
                if (!s_vl_p && s_valid) s_vl_rise = edges;
                if (s_vl_p && !s_valid && s_vl_rise >= 0) begin
                    check("small_valid_run", 64'(edges - s_vl_rise), 64'(32));
                    s_runs++;
                end
            end
            d_hs_p = d_hsync; d_vs_p = d_vsync; d_vl_p = d_valid;
            s_vs_p = s_vsync; s_fs_p = s_fs; s_vl_p = s_valid;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_dflt"}, 64'({d_h_addr, d_v_addr, d_fs, d_pclk, d_hsync, d_vsync, d_valid,
                                   d_r, d_g, d_b}), 64'(RESET_OUT));
        check({tag, "_small"}, 64'({s_h_addr, s_v_addr, s_fs, s_pclk, s_hsync, s_vsync, s_valid,
                                    s_r, s_g, s_b}), 64'(RESET_OUT));
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check_reset("reset_initial");
        #5 rst = 1'b0;

        // Address-coded colour: reach the first visible pixel of the full-size raster.
        repeat (58000) @(negedge clk);

        // All-ones colour: blanked pixels must still come out black.
        #5 mode = 1'b1;
        repeat (2000) @(negedge clk);
        #5 mode = 1'b0;

        // Asynchronous reset in the middle of a visible line of the small raster.
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (((edges / 2) % S_FRAME) == 244) begin
                found = 1'b1;
                break;
            end
        end
        check("reset_point_reached", 64'(found), 64'(1));
        #3 rst = 1'b1;
        #1 check_reset("reset_midline");
        repeat (3) @(negedge clk);
        #5 rst = 1'b0;
        repeat (2000) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing stage for the VGA output path: generates 640x480@60 Hz raster timing from the 50 MHz board clock.
- Produces pixel-clock, sync and blanking signals plus the current pixel address for the pixel source (logo/picture generator).
- Samples that source's 24-bit colour and presents sync, blank and RGB time-aligned to the VGA DAC pins.

Parameters:
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch

Ports:
clk  in  1  50 MHz system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
vga_data  in  24  pixel colour {R[23:16],G[15:8],B[7:0]} from the pixel source
h_addr  out  10  visible column 0..639 of the current pixel; 0 when blanked
v_addr  out  10  visible row 0..479; 0 when blanked
frame_start  out  1  one-clk pulse at start of each frame
pclk  out  1  25 MHz pixel clock to DAC
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
valid  out  1  high during visible area (drives BLANK_N)
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Line order: sync, back porch, active, front porch.
- Pixel enable: toggle register pix_en flips every clk; pclk = pix_en, registered. All raster state advances only on clk edges where pix_en = 1, giving 25 MHz pixel ticks.
- h_cnt: 0..H_TOTAL-1; on a tick, wraps to 0 after H_TOTAL-1, else increments.
- v_cnt: 0..V_TOTAL-1; increments only on a tick where h_cnt wraps; wraps to 0 after V_TOTAL-1.
- Active area: h_act = (H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE), i.e. 144..783. v_act defined likewise, i.e. 35..514.
- h_addr/v_addr: combinational from the counters.
  - h_addr = h_cnt-144 when h_act && v_act, else 0.
  - v_addr = v_cnt-35 when h_act && v_act, else 0.
  - The pixel source must return vga_data combinationally or within one clk, so it is stable by the next tick.
- Output stage, registered on each tick (one-pixel latency relative to counters/address):
  - hsync <= !(h_cnt < H_SYNC)
  - vsync <= !(v_cnt < V_SYNC)
  - valid <= h_act && v_act
  - {vga_r,vga_g,vga_b} <= (h_act && v_act) ? vga_data : 0
  - The address and its colour therefore appear together with valid on the following pixel period.
- frame_start: high for exactly one clk on the tick where h_cnt = 0 and v_cnt = 0 (after wrap); low otherwise.
- Reset (async, any time including mid-line): all internal and output state is forced immediately.
  - pix_en = 0, h_cnt = 0, v_cnt = 0, frame_start = 0, pclk = 0.
  - hsync = 1, vsync = 1, valid = 0, RGB = 0.
  - The first tick after release is the second clk edge; timing restarts from line 0, pixel 0.
- vga_data is ignored outside the active area; no X from vga_data may reach the RGB outputs while blanked.

Test Plan:
- Reset release, run 2 full frames -> measure pclk = 25 MHz; hsync period 1600 clk with low pulse 192 clk; vsync period 840000 clk with low pulse 2 lines (3200 clk); frame_start pulses every 840000 clk.
- vga_data = {h_addr[7:0], v_addr[7:0], 8'hA5} driven combinationally -> at each valid=1 pixel, RGB equals the address of the preceding tick; valid high for exactly 640 ticks per line, on 480 lines per frame.
- Corner addresses -> first visible pixel gives h_addr=0, v_addr=0 at h_cnt=144, v_cnt=35; last visible pixel gives h_addr=639, v_addr=479 at h_cnt=783, v_cnt=514; next tick gives h_addr=0, valid falls one tick later.
- vga_data forced to 24'hFFFFFF (or X) throughout -> RGB = 0 during every blanked tick, including porches and vsync lines.
- Assert rst for 3 clk at h_cnt=400, v_cnt=200 -> outputs take reset values within the same cycle; after release, first hsync low begins on the second clk edge and frame_start fires there.
- Wrap check at h_cnt=799, v_cnt=524 -> next tick both counters are 0 and frame_start=1 for one clk only.
